// File: rtl/d_mem_arbiter_pkg.sv
// Shared grant encodings and default bus widths for the data-memory arbiter.
package d_mem_arbiter_pkg;
   localparam logic [1:0] GNT_NONE = 2'd0;
   localparam logic [1:0] GNT_LD   = 2'd1;
   localparam logic [1:0] GNT_ST   = 2'd2;

   localparam int DEF_DATA_WIDTH   = 32;
   localparam int DEF_ADDRESS_BITS = 20;
   localparam int DEF_TAG_BITS     = 4;
endpackage

// File: rtl/d_mem_starve_ctr.sv
// Saturating consecutive-load counter; clear wins over increment, registered, no backpressure.
module d_mem_starve_ctr #(
   parameter int LIMIT = 4,
   parameter int W     = $clog2(LIMIT + 1)
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         inc,
   input  logic         clr,
   output logic         at_limit,
   output logic [W-1:0] count
);
   localparam logic [W-1:0] MAX = W'(LIMIT);

   always_ff @(posedge clock) begin
      if (reset || clr)
         count <= '0;
      else if (inc && count != MAX)
         count <= count + W'(1);
   end

   assign at_limit = (count == MAX);
endmodule

// File: rtl/d_mem_arbiter.sv
// Single-port data-memory arbiter (loads vs stores); grant is combinational, load response 1 cycle later.
// Optional DMEM_ARB_STATS_EN adds grant statistics counters shown on report.
module d_mem_arbiter
   import d_mem_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter int ADDRESS_BITS = DEF_ADDRESS_BITS,
   parameter int TAG_BITS     = DEF_TAG_BITS,
   parameter int STARVE_LIMIT = 4,
   parameter int CORE         = 0
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    ld_req_valid,
   input  logic [ADDRESS_BITS-1:0] ld_req_addr,
   input  logic [TAG_BITS-1:0]     ld_req_tag,
   output logic                    ld_req_ready,
   input  logic                    st_req_valid,
   input  logic [ADDRESS_BITS-1:0] st_req_addr,
   input  logic [DATA_WIDTH-1:0]   st_req_data,
   output logic                    st_req_ready,
   input  logic                    st_buf_full,
   input  logic                    flush,
   output logic                    ld_resp_valid,
   output logic [TAG_BITS-1:0]     ld_resp_tag,
   output logic [DATA_WIDTH-1:0]   ld_resp_data,
   output logic                    mem_read,
   output logic                    mem_write,
   output logic [ADDRESS_BITS-1:0] mem_address,
   output logic [DATA_WIDTH-1:0]   mem_in_data,
   input  logic [DATA_WIDTH-1:0]   mem_out_data,
   input  logic                    report
);
   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

   logic [1:0]          gnt;
   logic                at_limit;
   logic [CNT_W-1:0]    starve_cnt;
   logic                resp_pend;
   logic [TAG_BITS-1:0] resp_tag;

   // A waiting store only overtakes loads once the load streak hits the limit.
   always_comb begin
      gnt = GNT_NONE;
      if (reset)
         gnt = GNT_NONE;
      else if (st_req_valid && st_buf_full)
         gnt = GNT_ST;
      else if (ld_req_valid && !flush && (!at_limit || !st_req_valid))
         gnt = GNT_LD;
      else if (st_req_valid)
         gnt = GNT_ST;
   end

   assign ld_req_ready = (gnt == GNT_LD);
   assign st_req_ready = (gnt == GNT_ST);
   assign mem_read     = (gnt == GNT_LD);
   assign mem_write    = (gnt == GNT_ST);
   assign mem_address  = (gnt == GNT_LD) ? ld_req_addr :
                         (gnt == GNT_ST) ? st_req_addr : '0;
   assign mem_in_data  = (gnt == GNT_ST) ? st_req_data : '0;

   d_mem_starve_ctr #(
      .LIMIT (STARVE_LIMIT),
      .W     (CNT_W)
   ) u_starve (
      .clock    (clock),
      .reset    (reset),
      .inc      ((gnt == GNT_LD) && st_req_valid),
      .clr      ((gnt == GNT_ST) || !st_req_valid),
      .at_limit (at_limit),
      .count    (starve_cnt)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         resp_pend <= 1'b0;
         resp_tag  <= '0;
      end else begin
         resp_pend <= (gnt == GNT_LD);
         resp_tag  <= ld_req_tag;
      end
   end

   // Reset gating keeps a response pending from before reset off the outputs.
   assign ld_resp_valid = resp_pend && !flush && !reset;
   assign ld_resp_tag   = reset ? '0 : resp_tag;
   assign ld_resp_data  = ld_resp_valid ? mem_out_data : '0;

`ifdef DMEM_ARB_STATS_EN
   logic [31:0] cnt_cycles;
   logic [31:0] cnt_loads;
   logic [31:0] cnt_stores;
   logic [31:0] cnt_forced;
   logic        forced_st;

   assign forced_st = (gnt == GNT_ST) &&
                      (st_buf_full || (ld_req_valid && !flush && at_limit));

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_cycles <= '0;
         cnt_loads  <= '0;
         cnt_stores <= '0;
         cnt_forced <= '0;
      end else begin
         cnt_cycles <= cnt_cycles + 32'd1;
         if (gnt == GNT_LD) cnt_loads  <= cnt_loads + 32'd1;
         if (gnt == GNT_ST) cnt_stores <= cnt_stores + 32'd1;
         if (forced_st)     cnt_forced <= cnt_forced + 32'd1;
      end
   end
`endif

`ifndef SYNTHESIS
   always @(posedge clock) begin
      if (report && !reset) begin
`ifdef DMEM_ARB_STATS_EN
         $display("d_mem_arbiter core %0d: cycles=%0d loads=%0d stores=%0d forced=%0d starve_cnt=%0d",
                  CORE, cnt_cycles, cnt_loads, cnt_stores, cnt_forced, starve_cnt);
`else
         $display("d_mem_arbiter core %0d: grant=%0d starve_cnt=%0d", CORE, gnt, starve_cnt);
`endif
      end
   end
`endif
endmodule

// File: doc/d_mem_arbiter.md
Name: d_mem_arbiter

Overview:
- Shares the single-port data memory interface between the load queue (reads) and the store buffer (writes) of the out-of-order core.
- Issues at most one memory access per cycle and registers the load response valid/tag so it aligns with the 1-cycle read latency.
- Prevents store starvation with a bounded load-priority counter and honours an urgent store-buffer-full signal.
- Sits between LSU (load queue, store buffer) and d_mem_interface.

Parameters:
- DATA_WIDTH, 32, data word width
- ADDRESS_BITS, 20, memory address width
- TAG_BITS, 4, load-queue tag width returned with each load response
- STARVE_LIMIT, 4, max consecutive load grants while a store is waiting (1..15)
- CORE, 0, core id used in report output

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous active-high reset
- ld_req_valid  in  1  load request present
- ld_req_addr  in  ADDRESS_BITS  load address
- ld_req_tag  in  TAG_BITS  load-queue tag
- ld_req_ready  out  1  load accepted this cycle (grant)
- st_req_valid  in  1  store request present
- st_req_addr  in  ADDRESS_BITS  store address
- st_req_data  in  DATA_WIDTH  store data
- st_req_ready  out  1  store accepted this cycle (grant)
- st_buf_full  in  1  store buffer full; store gets absolute priority
- flush  in  1  pipeline flush; kills in-flight and same-cycle loads
- ld_resp_valid  out  1  load data valid
- ld_resp_tag  out  TAG_BITS  tag of returned load
- ld_resp_data  out  DATA_WIDTH  load data
- mem_read  out  1  to memory read enable
- mem_write  out  1  to memory write enable
- mem_address  out  ADDRESS_BITS  to memory address
- mem_in_data  out  DATA_WIDTH  to memory write data
- mem_out_data  in  DATA_WIDTH  from memory read data (valid 1 cycle after mem_read)
- report  in  1  print status

Behaviour:
- Grant (combinational, per cycle; none while reset=1):
  1. st_req_valid & st_buf_full -> store.
  2. Else ld_req_valid & !flush & (starve_cnt < STARVE_LIMIT | !st_req_valid) -> load.
  3. Else st_req_valid -> store.
  4. Else idle.
- Load grant: ld_req_ready=1, mem_read=1, mem_address=ld_req_addr, mem_write=0.
- Store grant: st_req_ready=1, mem_write=1, mem_address=st_req_addr, mem_in_data=st_req_data.
- Idle: mem_read=mem_write=0, mem_address=0, mem_in_data=0. Never both mem_read and mem_write.
- starve_cnt (width clog2(STARVE_LIMIT+1)):
  - +1 on load grant while st_req_valid, saturating at STARVE_LIMIT.
  - Clears to 0 on store grant or whenever st_req_valid=0.
- Response pipeline (registered):
  - resp_pend <= load_grant; resp_tag <= ld_req_tag.
  - ld_resp_valid = resp_pend & !flush; ld_resp_data = mem_out_data when valid, else 0; ld_resp_tag = resp_tag.
  - Load latency: grant in cycle N -> response in cycle N+1.
  - flush in cycle N+1 suppresses that response; flush in cycle N blocks the load grant, so a store may win instead.
- Back-to-back loads stream one per cycle. A store issued in cycle N+1 does not disturb the response of a load granted in cycle N.
- Reset: resp_pend=0, resp_tag=0, starve_cnt=0; all outputs 0 during reset. Reset mid-transaction drops the pending response.

Optional Feature:
- DMEM_ARB_STATS_EN defined: 32-bit counters for cycles, load grants, store grants, and forced stores (rule 1 or starvation).
  - All counters clear on reset.
  - On report, $display all counters with CORE and starve_cnt.
- DMEM_ARB_STATS_EN undefined: no counters; report prints grant state and starve_cnt only. Functional behaviour is identical in both builds.

Decomposition:
- Shared package: grant encoding constants (GNT_NONE=0, GNT_LD=1, GNT_ST=2) and the default DATA_WIDTH, ADDRESS_BITS and TAG_BITS values.
- One natural sub-module: d_mem_starve_ctr (saturating counter with clear; inputs inc, clr; output at_limit).
- Grant logic and the response register stay in the top module.

Test Plan:
- Load at 0x00010, tag 3, mem returns 0xDEADBEEF -> ld_req_ready in cycle N; ld_resp_valid, tag 3, data 0xDEADBEEF in N+1.
- Loads and a store both valid continuously, STARVE_LIMIT=4 -> grants L,L,L,L,S,L,L,L,L,S.
- Store valid with st_buf_full=1 plus load valid -> store granted immediately, ld_req_ready=0, starve_cnt=0 after.
- Load granted at N, flush=1 at N+1 -> ld_resp_valid=0 at N+1. flush at N with load+store valid -> store granted.
- Assert reset while resp_pend=1 -> ld_resp_valid=0 the next cycle; all outputs 0 during reset.
- Idle cycles between requests -> mem_read=mem_write=0, address 0. Check with a one-hot assertion every cycle.
